// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and WIDTH range limits.
// Imported by serial_add_ctrl.
package serial_add_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder: the single arithmetic slice reused every cycle by serial_add_ctrl.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: adds two WIDTH-bit operands LSB first through one full_adder.
// Optional subtract mode (sub port) is enabled with the SERIAL_ADD_SUB_EN macro.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
// in_ready is high only in IDLE; out_valid is high only in DONE and stays high,
// with sum/cout frozen, until out_ready is seen.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH out of range");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_cnt == CNT_LAST);

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: a + ~b + 1; cout=1 then means no borrow.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    full_adder u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_RUN;
            S_RUN:   if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE) && rst_n;
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    // Sum fills from the MSB so after WIDTH shifts bit 0 holds the first-computed LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_sum   <= (r_sum >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) r_cout <= w_fa_cout;
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADD_SUB_EN
    logic       sub;
`endif
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic [1:0] dbg_state;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;
    logic [1:0] dbg_state1;

    int checks = 0;
    int errors = 0;
    int lat;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1),
        .dbg_state (dbg_state1)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        check("in_ready_before_accept", in_ready, 1'b1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy, 1'b0);
        check("rst_sum",       sum, 8'h00);
        check("rst_cout",      cout, 1'b0);
        check("rst_state",     dbg_state, 2'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1'b1);

        // 0x3C + 0x42, latency check
        @(negedge clk);
        accept(8'h3C, 8'h42, 1'b0);
        check("run_busy", busy, 1'b1);
        check("run_in_ready", in_ready, 1'b0);
        wait_done(lat);
        check("lat_3c42", lat, 8);
        check("sum_3c42", sum, 8'h7E);
        check("cout_3c42", cout, 1'b0);
        check("done_state", dbg_state, 2'd2);
        pop();
        check("idle_out_valid", out_valid, 1'b0);
        check("idle_sum_hold", sum, 8'h7E);

        // wrap
        accept(8'hFF, 8'h01, 1'b0);
        wait_done(lat);
        check("sum_ff01", sum, 8'h00);
        check("cout_ff01", cout, 1'b1);

        // backpressure: operands presented during DONE must be ignored
        a = 8'h55; b = 8'h0A; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_sum", sum, 8'h00);
            check("bp_cout", cout, 1'b1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_idle_in_ready", in_ready, 1'b1);
        check("bp_idle_out_valid", out_valid, 1'b0);
        a = 8'h11; b = 8'h22; cin = 1'b0;
        step();
        in_valid = 1'b0;
        check("bp_new_accept_busy", busy, 1'b1);
        wait_done(lat);
        check("lat_1122", lat, 8);
        check("sum_1122", sum, 8'h33);
        check("cout_1122", cout, 1'b0);
        pop();

        // all ones with carry-in
        accept(8'hFF, 8'hFF, 1'b1);
        wait_done(lat);
        check("sum_ffff1", sum, 8'hFF);
        check("cout_ffff1", cout, 1'b1);
        pop();

        // reset in the third RUN cycle
        accept(8'h3C, 8'h42, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_sum", sum, 8'h00);
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        accept(8'h01, 8'h01, 1'b0);
        wait_done(lat);
        check("lat_0101", lat, 8);
        check("sum_0101", sum, 8'h02);
        check("cout_0101", cout, 1'b0);
        pop();

        // WIDTH=1 instance
        check("w1_in_ready", in_ready1, 1'b1);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        check("w1_run_out_valid", out_valid1, 1'b0);
        step();
        check("w1_out_valid", out_valid1, 1'b1);
        check("w1_sum", sum1, 1'b1);
        check("w1_cout", cout1, 1'b1);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("w1_idle", busy1, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        accept(8'h10, 8'h01, 1'b0);
        wait_done(lat);
        check("sub_1001_sum", sum, 8'h0F);
        check("sub_1001_cout", cout, 1'b1);
        pop();
        accept(8'h01, 8'h02, 1'b0);
        wait_done(lat);
        check("sub_0102_sum", sum, 8'hFF);
        check("sub_0102_cout", cout, 1'b0);
        pop();
        sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
